// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: tracks destination registers of in-flight
// long-latency ops and stalls ID on RAW/WAW against them or when the
// outstanding-op limit is reached.
module hazard_scoreboard #(
    parameter int unsigned MAXPEND = 3,
    parameter int unsigned CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [4:0]      id_rd,
    input  logic            id_regwr,
    input  logic            id_long,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            cnt_clr,
    output logic            stall,
    output logic            issue,
    output logic [31:0]     pending,
    output logic [4:0]      pend_cnt,
    output logic            err,
    output logic [CNTW-1:0] stall_cycles
);

    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic            raw1;
    logic            raw2;
    logic            trk;
    logic            waw;
    logic            full;
    logic            do_set;
    logic            do_clr;
    logic            bad_wb;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] pending_nxt;
    logic [RW-1:0]   pend_cnt_nxt;

    // Hazard detection against the registered pending map (no wb bypass)
    always_comb begin
        raw1   = 1'b0;
        raw2   = 1'b0;
        trk    = 1'b0;
        waw    = 1'b0;
        full   = 1'b0;
        stall  = 1'b0;
        issue  = 1'b0;
        raw1   = id_rs1_used && (id_rs1 != '0) && pending[id_rs1];
        raw2   = id_rs2_used && (id_rs2 != '0) && pending[id_rs2];
        trk    = id_regwr && id_long && (id_rd != '0);
        waw    = trk && pending[id_rd];
        full   = trk && (pend_cnt == RW'(MAXPEND));
        stall  = id_valid && !flush && (raw1 || raw2 || waw || full);
        issue  = id_valid && !flush && !(raw1 || raw2 || waw || full);
    end

    // Next pending map and occupancy count from set/clear events
    always_comb begin
        do_set       = issue && trk;
        do_clr       = wb_valid && (wb_rd != '0) && pending[wb_rd];
        bad_wb       = wb_valid && !do_clr;
        set_vec      = do_set ? (NREG'(1) << id_rd) : '0;
        clr_vec      = do_clr ? (NREG'(1) << wb_rd) : '0;
        pending_nxt  = (pending | set_vec) & ~clr_vec & ~NREG'(1);
        pend_cnt_nxt = pend_cnt;
        case ({do_set, do_clr})
            2'b10:   pend_cnt_nxt = pend_cnt + RW'(1);
            2'b01:   pend_cnt_nxt = pend_cnt - RW'(1);
            default: pend_cnt_nxt = pend_cnt;
        endcase
    end

    // Scoreboard state and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            pend_cnt <= '0;
            err      <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= pend_cnt_nxt;
            err      <= err | bad_wb;
        end
    end

    // Saturating stall-cycle performance counter with synchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNTW'(1);
        end
    end

endmodule
